// File: rtl/pattern_mealy_detector.sv
`default_nettype none
// ============================================================================
// Module      : pattern_mealy_detector
// Description : Serial detector for a runtime-loadable pattern of up to PAT_W
//               bits. The match flag is Mealy (same cycle as the last bit),
//               overlap is selectable, and matches are counted with saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module pattern_mealy_detector #(
    parameter int PAT_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         a,
    input  logic                         in_valid,
    input  logic                         clr,
    input  logic                         cfg_load,
    input  logic [PAT_W-1:0]             cfg_pattern,
    input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
    input  logic                         cfg_overlap,
    output logic                         y,
    output logic [CNT_W-1:0]             match_count,
    output logic                         count_sat
);

    localparam int LEN_W  = $clog2(PAT_W + 1);
    localparam int FILL_W = $clog2(PAT_W);

    localparam logic [LEN_W-1:0]  c_len_max  = LEN_W'(PAT_W);
    localparam logic [FILL_W-1:0] c_fill_max = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

    logic [PAT_W-1:0]  r_pat;
    logic [LEN_W-1:0]  r_len;
    logic              r_ovl;
    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;
    logic [CNT_W-1:0]  r_cnt;

    logic [LEN_W-1:0]  w_len;
    logic [PAT_W-1:0]  w_window;
    logic [PAT_W-1:0]  w_mask;
    logic              w_fill_ok;
    logic              w_match;

    always_comb begin
        w_len    = (r_len > c_len_max) ? c_len_max : r_len;
        w_window = {r_hist, a};
        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (LEN_W'(i) < w_len);
        end
        // Require L-1 real history bits so reset-zeroed history never matches.
        w_fill_ok = (LEN_W'(r_fill) + LEN_W'(1)) >= w_len;
        w_match   = in_valid && !cfg_load && !clr && (w_len != '0) && w_fill_ok
                    && (((w_window ^ r_pat) & w_mask) == '0);
    end

    assign y           = w_match;
    assign match_count = r_cnt;
    assign count_sat   = (r_cnt == c_cnt_max);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pat  <= '0;
            r_len  <= '0;
            r_ovl  <= 1'b1;
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
        end else if (cfg_load) begin
            r_pat  <= cfg_pattern;
            r_len  <= cfg_len;
            r_ovl  <= cfg_overlap;
            r_hist <= '0;
            r_fill <= '0;
        end else if (clr) begin
            r_hist <= '0;
            r_fill <= '0;
            r_cnt  <= '0;
        end else if (in_valid) begin
            if (w_match && !r_ovl) begin
                r_hist <= '0;
                r_fill <= '0;
            end else begin
                r_hist <= w_window[PAT_W-2:0];
                if (r_fill != c_fill_max) begin
                    r_fill <= r_fill + FILL_W'(1);
                end
            end
            if (w_match && (r_cnt != c_cnt_max)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_mealy_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_pattern_mealy_detector
// Description : Self-checking bench: vector tables, hand sequences and a
//               queue-based reference model under random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pattern_mealy_detector;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // Instance A: PAT_W=4, CNT_W=16
    logic        aa, av, aclr, ald, aovl, ay, asat;
    logic [3:0]  apat;
    logic [2:0]  alen;
    logic [15:0] acnt;
    // Instance B: PAT_W=2, CNT_W=2
    logic        ba, bv, bclr, bld, bovl, by, bsat;
    logic [1:0]  bpat, blen, bcnt;

    pattern_mealy_detector #(.PAT_W(4), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .a(aa), .in_valid(av), .clr(aclr),
        .cfg_load(ald), .cfg_pattern(apat), .cfg_len(alen), .cfg_overlap(aovl),
        .y(ay), .match_count(acnt), .count_sat(asat)
    );

    pattern_mealy_detector #(.PAT_W(2), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .a(ba), .in_valid(bv), .clr(bclr),
        .cfg_load(bld), .cfg_pattern(bpat), .cfg_len(blen), .cfg_overlap(bovl),
        .y(by), .match_count(bcnt), .count_sat(bsat)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the list of valid bits seen since the last clear.
    bit [3:0] m_pat;
    int       m_len;
    bit       m_ovl;
    bit       m_q[$];
    int       m_cnt;

    function automatic bit m_match(bit v, bit a, bit c, bit l);
        int L;
        bit b;
        if (!v || c || l) return 1'b0;
        L = (m_len > 4) ? 4 : m_len;
        if (L == 0) return 1'b0;
        if (m_q.size() + 1 < L) return 1'b0;
        for (int k = 0; k < L; k++) begin
            b = (k == 0) ? a : m_q[m_q.size() - k];
            if (b != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic m_reset();
        m_pat = '0; m_len = 0; m_ovl = 1'b1; m_q.delete(); m_cnt = 0;
    endtask

    task automatic stepA(input bit v, input bit a, input bit c, input bit l,
                         input bit [3:0] p, input int len, input bit o,
                         output bit yo, output int co);
        bit exp;
        av = v; aa = a; aclr = c; ald = l; apat = p; alen = 3'(len); aovl = o;
        @(negedge clk);
        exp = m_match(v, a, c, l);
        yo  = ay;
        chk("a_y", 32'(ay), 32'(exp));
        @(posedge clk); #1;
        if (l) begin
            m_pat = p; m_len = len; m_ovl = o; m_q.delete();
        end else if (c) begin
            m_q.delete(); m_cnt = 0;
        end else if (v) begin
            if (exp && !m_ovl) m_q.delete();
            else begin
                m_q.push_back(a);
                if (m_q.size() > 4) void'(m_q.pop_front());
            end
            if (exp && m_cnt < 65535) m_cnt++;
        end
        co = int'(acnt);
        chk("a_cnt", 32'(acnt), 32'(m_cnt));
    endtask

    task automatic bitA(input bit v, input bit a);
        bit y; int c;
        stepA(v, a, 1'b0, 1'b0, 4'd0, 0, 1'b0, y, c);
    endtask

    task automatic loadA(input bit [3:0] p, input int len, input bit o);
        bit y; int c;
        stepA(1'b0, 1'b0, 1'b0, 1'b1, p, len, o, y, c);
    endtask

    task automatic stepB(input bit v, input bit a, input bit c, input bit l,
                         input bit ey, input int ecnt, input bit esat);
        bv = v; ba = a; bclr = c; bld = l;
        @(negedge clk);
        chk("b_y", 32'(by), 32'(ey));
        @(posedge clk); #1;
        chk("b_cnt", 32'(bcnt), 32'(ecnt));
        chk("b_sat", 32'(bsat), 32'(esat));
    endtask

    typedef struct {
        bit v;
        bit a;
        bit ey;
        int ecnt;
    } vec_t;

    vec_t tbl[14];

    initial begin
        bit [6:0] s  = 7'b1011011;
        bit [6:0] e1 = 7'b0001001;
        bit [6:0] e2 = 7'b0001000;
        int c1[7] = '{0, 0, 0, 1, 1, 1, 2};
        int c2[7] = '{2, 2, 2, 3, 3, 3, 3};
        bit yv;
        int cv;
        int r;

        for (int i = 0; i < 7; i++) begin
            tbl[i]     = '{1'b1, s[6-i], e1[6-i], c1[i]};
            tbl[i + 7] = '{1'b1, s[6-i], e2[6-i], c2[i]};
        end

        reset = 1'b1;
        aa = 0; av = 0; aclr = 0; ald = 0; aovl = 0; apat = '0; alen = '0;
        ba = 0; bv = 0; bclr = 0; bld = 0; bovl = 1; bpat = '0; blen = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        av = 1'b1; aa = 1'b1;
        #1;
        chk("rst_a_y", 32'(ay), 32'd0);
        chk("rst_a_cnt", 32'(acnt), 32'd0);
        chk("rst_a_sat", 32'(asat), 32'd0);
        chk("rst_b_cnt", 32'(bcnt), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        av = 1'b0;
        // Detector disabled after reset: stream never matches.
        for (int i = 0; i < 4; i++) bitA(1'b1, s[6-i]);

        // Table vectors: overlapping then non-overlapping 1011.
        loadA(4'b1011, 4, 1'b1);
        for (int i = 0; i < 14; i++) begin
            if (i == 7) loadA(4'b1011, 4, 1'b0);
            stepA(tbl[i].v, tbl[i].a, 1'b0, 1'b0, 4'd0, 0, 1'b0, yv, cv);
            chk("tbl_y", 32'(yv), 32'(tbl[i].ey));
            chk("tbl_cnt", 32'(cv), 32'(tbl[i].ecnt));
        end

        // Invalid gaps with toggling data are ignored.
        loadA(4'b1011, 4, 1'b1);
        for (int i = 0; i < 7; i++) begin
            bitA(1'b1, s[6-i]);
            repeat (3) bitA(1'b0, 1'($urandom));
        end
        chk("gap_cnt", 32'(acnt), 32'd5);

        // cfg_load on the final pattern bit discards it.
        loadA(4'b1011, 4, 1'b1);
        bitA(1'b1, 1'b1); bitA(1'b1, 1'b0); bitA(1'b1, 1'b1);
        stepA(1'b1, 1'b1, 1'b0, 1'b1, 4'b1011, 4, 1'b1, yv, cv);
        chk("ld_y", 32'(yv), 32'd0);
        bitA(1'b1, 1'b1); bitA(1'b1, 1'b0); bitA(1'b1, 1'b1);
        stepA(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 0, 1'b0, yv, cv);
        chk("ld_match_y", 32'(yv), 32'd1);
        chk("ld_match_cnt", 32'(cv), 32'd6);

        // Asynchronous reset mid-stream.
        bitA(1'b1, 1'b0); bitA(1'b1, 1'b1);
        av = 1'b1; aa = 1'b1;
        reset = 1'b1;
        #2;
        chk("arst_y", 32'(ay), 32'd0);
        chk("arst_cnt", 32'(acnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        m_reset();
        for (int i = 0; i < 7; i++) bitA(1'b1, s[6-i]);
        chk("arst_nomatch_cnt", 32'(acnt), 32'd0);

        // Randomised traffic against the reference model, including len clamp.
        repeat (40) begin
            loadA(4'($urandom), $urandom_range(0, 6), 1'($urandom));
            repeat (20) begin
                r = $urandom_range(0, 99);
                if (r < 3)
                    stepA(1'($urandom), 1'($urandom), 1'b1, 1'b0, 4'd0, 0, 1'b0, yv, cv);
                else if (r < 5)
                    stepA(1'($urandom), 1'($urandom), 1'b0, 1'b1, 4'($urandom),
                          $urandom_range(0, 7), 1'($urandom), yv, cv);
                else
                    bitA(r < 75, 1'($urandom));
            end
        end

        // PAT_W=2 legacy pattern 01: combinational response within the cycle.
        bpat = 2'b01; blen = 2'd2; bovl = 1'b1;
        stepB(0, 0, 0, 1, 0, 0, 0);
        stepB(1, 1, 0, 0, 0, 0, 0);
        stepB(1, 0, 0, 0, 0, 0, 0);
        bv = 1'b1; ba = 1'b1;
        #2;
        chk("b_comb_hi", 32'(by), 32'd1);
        ba = 1'b0;
        #1;
        chk("b_comb_lo", 32'(by), 32'd0);
        ba = 1'b1;
        #1;
        chk("b_comb_hi2", 32'(by), 32'd1);
        @(posedge clk); #1;
        chk("b_comb_cnt", 32'(bcnt), 32'd1);

        // Saturating 2-bit counter with pattern 11, then clear.
        bpat = 2'b11;
        stepB(0, 0, 0, 1, 0, 1, 0);
        stepB(0, 0, 1, 0, 0, 0, 0);
        stepB(1, 1, 0, 0, 0, 0, 0);
        stepB(1, 1, 0, 0, 1, 1, 0);
        stepB(1, 1, 0, 0, 1, 2, 0);
        stepB(1, 1, 0, 0, 1, 3, 1);
        stepB(1, 1, 0, 0, 1, 3, 1);
        stepB(1, 1, 0, 0, 1, 3, 1);
        stepB(1, 1, 1, 0, 0, 0, 0);
        stepB(1, 1, 0, 0, 0, 0, 0);
        stepB(1, 1, 0, 0, 1, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
